// File: rtl/temp_window_counter_pkg.sv
// Shared types and default widths for the windowed temperature-oscillator counter.
package temp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COUNT,
    DONE
  } temp_state_t;

  localparam int TEMP_WIDTH     = 10;
  localparam int TEMP_WIN_WIDTH = 16;

endpackage

// File: rtl/temp_window_counter_edge_sync.sv
// Brings the asynchronous oscillator into the clk domain and flags each rising edge
// as a one-cycle pulse.
module temp_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic osc_in,
  output logic osc_edge
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], osc_in};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign osc_edge = sync[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/temp_window_counter.sv
// Counts oscillator rising edges over a programmable clk window and reports a
// saturating result through a start/busy/done handshake.
module temp_window_counter
  import temp_pkg::*;
#(
  parameter int WIDTH       = TEMP_WIDTH,
  parameter int WIN_WIDTH   = TEMP_WIN_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 osc_in,
  input  logic                 start,
  input  logic                 continuous,
  input  logic [WIN_WIDTH-1:0] window_len,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 result_valid,
  output logic                 overflow
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  temp_state_t          state_q, state_d;
  logic [WIN_WIDTH-1:0] win_cnt;
  logic [WIDTH-1:0]     edge_cnt;
  logic                 sat;
  logic                 osc_edge;

  temp_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk      (clk),
    .reset    (reset),
    .osc_in   (osc_in),
    .osc_edge (osc_edge)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: next state defaults to the current one before the case so no path
  // leaves state_d unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = ARM;
      ARM:   state_d = (window_len == '0) ? DONE : COUNT;
      COUNT: if (win_cnt == WIN_WIDTH'(1)) state_d = DONE;
      DONE:  state_d = continuous ? ARM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Edges arriving during ARM are dropped because the counter is being cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt      <= '0;
      edge_cnt     <= '0;
      sat          <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      unique case (state_q)
        ARM: begin
          edge_cnt <= '0;
          sat      <= 1'b0;
          win_cnt  <= window_len;
        end
        COUNT: begin
          win_cnt <= win_cnt - WIN_WIDTH'(1);
          if (osc_edge && (edge_cnt != CNT_MAX)) begin
            edge_cnt <= edge_cnt + WIDTH'(1);
            if (edge_cnt == CNT_MAX - WIDTH'(1)) sat <= 1'b1;
          end
        end
        DONE: begin
          result       <= edge_cnt;
          overflow     <= sat;
          result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_window_counter.sv
// Scenario bench for temp_window_counter; expected counts come from a log of the
// driven oscillator and the window timing rules.
module tb_temp_window_counter;

  localparam int W    = 10;
  localparam int WW   = 16;
  localparam int S    = 2;
  localparam int MAXV = (1 << W) - 1;

  logic          clk        = 1'b0;
  logic          reset      = 1'b0;
  logic          osc_in     = 1'b0;
  logic          start      = 1'b0;
  logic          continuous = 1'b0;
  logic [WW-1:0] window_len = '0;
  logic          busy, done, result_valid, overflow;
  logic [W-1:0]  result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int osc_mode = 0;            // 0: toggle every clk, 1: random level
  bit osc_log [0:16383];

  always #5 clk = ~clk;

  temp_window_counter #(.WIDTH(W), .WIN_WIDTH(WW), .SYNC_STAGES(S)) dut (
    .clk          (clk),
    .reset        (reset),
    .osc_in       (osc_in),
    .start        (start),
    .continuous   (continuous),
    .window_len   (window_len),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .result_valid (result_valid),
    .overflow     (overflow)
  );

  // One clk cycle: cyc names the cycle that begins at this posedge.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    if (osc_mode == 0) osc_in = ~osc_in;
    else               osc_in = 1'($urandom);
    osc_log[cyc] = osc_in;
  endtask

  // Rising edges of osc_in seen by the counter over the n counting cycles from first.
  function automatic int raw_edges(input int first, input int n);
    int r = 0;
    for (int c = first; c < first + n; c++)
      if (osc_log[c-S] && !osc_log[c-S-1]) r++;
    return r;
  endfunction

  task automatic run_window(input int n, output int t, output int done_c,
                            output logic [W-1:0] res, output logic ovf, output logic vld,
                            output int busy_n, output int done_n);
    done_c = -1; busy_n = 0; done_n = 0;
    window_len = WW'(n);
    start = 1'b1;
    t = cyc;
    step();
    start = 1'b0;
    for (int i = 0; i < n + 20; i++) begin
      if (cyc == t + 2) window_len = WW'($urandom);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_c < 0) done_c = cyc;
      end
      if (!busy && done_c >= 0) break;
      step();
    end
    res = result; ovf = overflow; vld = result_valid;
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
    total++; if (result !== '0) begin bad++; $display("FAIL reset_result: got %0d expected 0", result); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    reset = 1'b1;
    repeat (6) step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    int t, dc, bn, dn; logic [W-1:0] r; logic o, v;
    osc_mode = 0;
    run_window(8, t, dc, r, o, v, bn, dn);
    total++; if (dc !== t + 10) begin bad++; $display("FAIL basic_done_cycle: got %0d expected %0d", dc, t + 10); end
    total++; if (r !== 10'd4) begin bad++; $display("FAIL basic_result: got %0d expected 4", r); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL basic_overflow: got %b expected 0", o); end
    total++; if (v !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b expected 1", v); end
    total++; if (bn !== 10) begin bad++; $display("FAIL basic_busy_cycles: got %0d expected 10", bn); end
    total++; if (dn !== 1) begin bad++; $display("FAIL basic_done_count: got %0d expected 1", dn); end
  endtask

  task automatic test_saturation();
    int t, dc, bn, dn; logic [W-1:0] r; logic o, v;
    osc_mode = 0;
    run_window(4000, t, dc, r, o, v, bn, dn);
    total++; if (dc !== t + 4002) begin bad++; $display("FAIL sat_done_cycle: got %0d expected %0d", dc, t + 4002); end
    total++; if (r !== 10'd1023) begin bad++; $display("FAIL sat_result: got %0d expected 1023", r); end
    total++; if (o !== 1'b1) begin bad++; $display("FAIL sat_overflow: got %b expected 1", o); end
    run_window(8, t, dc, r, o, v, bn, dn);
    total++; if (r !== 10'd4) begin bad++; $display("FAIL sat_next_result: got %0d expected 4", r); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL sat_next_overflow: got %b expected 0", o); end
  endtask

  task automatic test_zero_window();
    int t, dc, bn, dn; logic [W-1:0] r; logic o, v;
    osc_mode = 0;
    run_window(0, t, dc, r, o, v, bn, dn);
    total++; if (dc !== t + 2) begin bad++; $display("FAIL zero_done_cycle: got %0d expected %0d", dc, t + 2); end
    total++; if (r !== 10'd0) begin bad++; $display("FAIL zero_result: got %0d expected 0", r); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL zero_overflow: got %b expected 0", o); end
    total++; if (bn !== 2) begin bad++; $display("FAIL zero_busy_cycles: got %0d expected 2", bn); end
  endtask

  task automatic test_continuous();
    int t, expd, got, extra;
    osc_mode = 0;
    continuous = 1'b1;
    window_len = WW'(6);
    start = 1'b1;
    t = cyc;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expd = t + 8 * (k + 1);
      for (int i = 0; i < 20 && !done; i++) begin
        if (k == 3 && cyc >= expd - 3) continuous = 1'b0;
        step();
      end
      got = done ? cyc : -1;
      total++; if (got !== expd) begin bad++; $display("FAIL cont_done_cycle[%0d]: got %0d expected %0d", k, got, expd); end
      step();
      total++; if (result !== 10'd3) begin bad++; $display("FAIL cont_result[%0d]: got %0d expected 3", k, result); end
      total++; if (busy !== (k < 3)) begin bad++; $display("FAIL cont_busy_after[%0d]: got %b expected %b", k, busy, k < 3); end
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) extra++;
      step();
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL cont_stop_idle: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    int t, dc, bn, dn; logic [W-1:0] r; logic o, v;
    osc_mode = 0;
    window_len = WW'(8);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    #2 reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    total++; if (result !== '0) begin bad++; $display("FAIL rst_mid_result: got %0d expected 0", result); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b expected 0", result_valid); end
    total++; if (done !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL rst_mid_done_ovf: got %b%b expected 00", done, overflow); end
    repeat (3) step();
    reset = 1'b1;
    repeat (6) step();
    run_window(8, t, dc, r, o, v, bn, dn);
    total++; if (r !== 10'd4) begin bad++; $display("FAIL rst_after_result: got %0d expected 4", r); end
    total++; if (v !== 1'b1) begin bad++; $display("FAIL rst_after_valid: got %b expected 1", v); end
  endtask

  task automatic test_ignored_start();
    int t, bn, dn;
    osc_mode = 0;
    window_len = WW'(8);
    start = 1'b1;
    t = cyc;
    step();
    bn = 0; dn = 0;
    for (int i = 0; i < 30; i++) begin
      start = (cyc == t + 4) || (cyc == t + 10);
      if (busy) bn++;
      if (done) dn++;
      step();
    end
    start = 1'b0;
    total++; if (dn !== 1) begin bad++; $display("FAIL ign_done_count: got %0d expected 1", dn); end
    total++; if (bn !== 10) begin bad++; $display("FAIL ign_busy_cycles: got %0d expected 10", bn); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_final_busy: got %b expected 0", busy); end
  endtask

  task automatic test_random();
    int t, dc, bn, dn, n, raw, exp_r; logic [W-1:0] r; logic o, v;
    osc_mode = 1;
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(0, 40);
      repeat ($urandom_range(0, 3)) step();
      run_window(n, t, dc, r, o, v, bn, dn);
      raw   = raw_edges(t + 2, n);
      exp_r = (raw > MAXV) ? MAXV : raw;
      total++; if (dc !== t + 2 + n) begin bad++; $display("FAIL rnd_done_cycle[%0d]: got %0d expected %0d", k, dc, t + 2 + n); end
      total++; if (r !== W'(exp_r)) begin bad++; $display("FAIL rnd_result[%0d] n=%0d: got %0d expected %0d", k, n, r, exp_r); end
      total++; if (o !== (raw >= MAXV)) begin bad++; $display("FAIL rnd_overflow[%0d]: got %b expected %b", k, o, raw >= MAXV); end
      total++; if (bn !== n + 2) begin bad++; $display("FAIL rnd_busy_cycles[%0d]: got %0d expected %0d", k, bn, n + 2); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_zero_window();
    test_continuous();
    test_reset_mid();
    test_ignored_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
